// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state encoding, NOP encoding and default fetch parameters
package fetch_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, REDIR = 2'd2} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int DEF_PC_STEP = 4;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID slot (pc, instruction, valid); flush beats load, neither holds; ports clk, rst (async low), load, flush, pc_in, instr_in -> pc, instruction, valid
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      instruction <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      pc <= '0;
      instruction <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc <= pc_in;
      instruction <= instr_in;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, next-PC mux, RUN/HOLD/REDIR FSM and IF/ID slot; ports clk, rst (async low), freeze, branch_taken, branch_addr, imem_addr, imem_rdata, pc_id, instruction_id, valid_id, fetch_state, plus stall_cnt/flush_cnt when FETCH_PERF_CNT_EN is defined
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          PC_STEP  = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_id,
  output logic [31:0] instruction_id,
  output logic        valid_id,
  output logic [1:0]  fetch_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  logic [31:0] pc, pc_seq;
  state_t state;
  assign pc_seq = pc + 32'(PC_STEP);
  assign imem_addr = pc;
  assign fetch_state = state;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      state <= RUN;
    end else begin
      pc <= branch_taken ? {branch_addr[31:2], 2'b00} : freeze ? pc : pc_seq;
      state <= branch_taken ? REDIR : freeze ? HOLD : RUN;
    end
  end
  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (!freeze),
    .flush      (branch_taken),
    .pc_in      (pc_seq),
    .instr_in   (imem_rdata),
    .pc         (pc_id),
    .instruction(instruction_id),
    .valid      (valid_id)
  );
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= (freeze && !branch_taken && stall_cnt != '1) ? stall_cnt + 32'd1 : stall_cnt;
      flush_cnt <= (branch_taken && flush_cnt != '1) ? flush_cnt + 32'd1 : flush_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random stimulus against a rule-level reference model of the fetch stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] imem_addr, imem_rdata, pc_id, instruction_id;
  logic        valid_id;
  logic [1:0]  fetch_state;
  logic [31:0] key = 32'h1234_5678;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc, m_pcid, m_ins;
  logic        m_val;
  int          m_st;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall, m_flush;
`endif

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr ^ key) * 32'h9E37_79B1;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_addr   (branch_addr),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc_id         (pc_id),
    .instruction_id(instruction_id),
    .valid_id      (valid_id),
    .fetch_state   (fetch_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a ^ key) * 32'h9E37_79B1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_addr"}, imem_addr, m_pc);
    check({tag, ".pc_id"}, pc_id, m_pcid);
    check({tag, ".instruction_id"}, instruction_id, m_ins);
    check({tag, ".valid_id"}, 32'(valid_id), 32'(m_val));
    check({tag, ".fetch_state"}, 32'(fetch_state), 32'(m_st));
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".stall_cnt"}, stall_cnt, m_stall);
    check({tag, ".flush_cnt"}, flush_cnt, m_flush);
`endif
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pcid = 32'h0; m_ins = 32'h0; m_val = 1'b0; m_st = 0;
`ifdef FETCH_PERF_CNT_EN
    m_stall = 32'h0; m_flush = 32'h0;
`endif
  endtask

  task automatic step(input logic f, input logic b, input logic [31:0] a, input string tag);
    freeze = f; branch_taken = b; branch_addr = a;
    #1 check({tag, ".no_comb_path"}, imem_addr, m_pc);
    @(posedge clk);
    if (b) begin
      m_pc = a & ~32'd3; m_pcid = 0; m_ins = 0; m_val = 0; m_st = 2;
    end else if (f) begin
      m_st = 1;
    end else begin
      m_ins = mem(m_pc); m_pcid = m_pc + 4; m_val = 1; m_pc = m_pc + 4; m_st = 0;
    end
`ifdef FETCH_PERF_CNT_EN
    if (b && m_flush != 32'hFFFF_FFFF) m_flush++;
    if (f && !b && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
    #1 check_all(tag);
  endtask

  initial begin
    key = $urandom;
    model_reset();
    #2 check_all("reset");
    @(negedge clk) rst = 1'b1;
    step(0, 0, 0, "run_a");
    step(0, 0, 0, "run_b");
    step(1, 0, 0, "freeze1");
    step(1, 0, 0, "freeze2");
    step(0, 0, 0, "release");
    step(0, 1, 32'h40, "branch40");
    step(0, 0, 0, "target40");
    step(1, 1, 32'h23, "branch_freeze");
    step(1, 0, 0, "hold_after_redir");
    step(0, 0, 0, "after_hold");
    step(0, 1, 32'hFFFF_FFFC, "branch_top");
    step(0, 0, 0, "top_fetch");
    step(0, 0, 0, "wrap");
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom, "random");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
